// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state types and initial-carry helper for the multiword ALU sequencer.
package alu_pkg;

    typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBB = 2'b11} alu_arith_op_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} seq_state_t;

    // Subtraction runs as A + ~B + 1, so SUB seeds 1 and SBB seeds the inverted borrow.
    function automatic logic init_carry(alu_arith_op_t op, logic cf_in);
        return op == ADD ? 1'b0 : op == SUB ? 1'b1 : op == ADC ? cf_in : ~cf_in;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: one combinational WORD_WIDTH-bit add slice with optional B inversion.
module adder_slice #(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] A,
    input  logic [WORD_WIDTH-1:0] B,
    input  logic                  INVERT_B,
    input  logic                  CIN,
    output logic [WORD_WIDTH-1:0] S,
    output logic                  COUT
);

    always_comb {COUT, S} = {1'b0, A} + {1'b0, INVERT_B ? ~B : B} + {{WORD_WIDTH{1'b0}}, CIN};

endmodule

// File: rtl/alu_multiword_sequencer.sv
// alu_multiword_sequencer: runs a WORDS*WORD_WIDTH add/sub through one adder slice,
// least significant word first, with carry chained in a register.
import alu_pkg::*;

module alu_multiword_sequencer #(
    parameter int WORD_WIDTH = 8,
    parameter int WORDS      = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        START_VALID,
    output logic                        START_READY,
    input  logic [1:0]                  OP,
    input  logic                        CF_IN,
    input  logic [WORDS*WORD_WIDTH-1:0] A,
    input  logic [WORDS*WORD_WIDTH-1:0] B,
    output logic                        RESULT_VALID,
    input  logic                        RESULT_READY,
    output logic [WORDS*WORD_WIDTH-1:0] R,
    output logic                        CF_OUT,
    output logic                        ZF_OUT,
    output logic                        OF_OUT
);

    localparam int N  = WORDS * WORD_WIDTH;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    seq_state_t            state, state_next;
    alu_arith_op_t         op_q;
    logic [IW-1:0]         idx;
    logic                  carry;
    logic [N-1:0]          a_q, b_q, r_q, r_next;
    logic [WORD_WIDTH-1:0] a_sl, b_sl, bx, s;
    logic                  c, invert, cf, zf, of;

    assign START_READY  = state == IDLE;
    assign RESULT_VALID = state == DONE;
    assign R            = r_q;
    assign CF_OUT       = cf;
    assign ZF_OUT       = zf;
    assign OF_OUT       = of;

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = START_VALID ? BUSY : IDLE;
            BUSY:    state_next = idx == LAST ? DONE : BUSY;
            DONE:    state_next = RESULT_READY ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        invert = op_q == SUB || op_q == SBB;
        a_sl   = a_q[idx*WORD_WIDTH +: WORD_WIDTH];
        b_sl   = b_q[idx*WORD_WIDTH +: WORD_WIDTH];
        bx     = invert ? ~b_sl : b_sl;
        r_next = r_q;
        r_next[idx*WORD_WIDTH +: WORD_WIDTH] = s;
    end

    adder_slice #(.WORD_WIDTH(WORD_WIDTH)) u_slice (
        .A        (a_sl),
        .B        (b_sl),
        .INVERT_B (invert),
        .CIN      (carry),
        .S        (s),
        .COUT     (c)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q  <= ADD;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            cf    <= 1'b0;
            zf    <= 1'b0;
            of    <= 1'b0;
        end else if (state == IDLE && START_VALID) begin
            op_q  <= alu_arith_op_t'(OP);
            a_q   <= A;
            b_q   <= B;
            carry <= init_carry(alu_arith_op_t'(OP), CF_IN);
            idx   <= '0;
        end else if (state == BUSY) begin
            r_q   <= r_next;
            carry <= c;
            idx   <= idx == LAST ? idx : idx + 1'b1;
            // Flags only settle once the top slice is in; ZF sees the freshly written slice too.
            if (idx == LAST) begin
                cf <= invert ? ~c : c;
                zf <= r_next == '0;
                of <= (a_sl[WORD_WIDTH-1] == bx[WORD_WIDTH-1]) && (s[WORD_WIDTH-1] != a_sl[WORD_WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// tb_alu_multiword_sequencer: directed scoreboard bench for the 4x8-bit multiword sequencer.
module tb_alu_multiword_sequencer;

    typedef struct packed {
        logic [31:0] r;
        logic        cf;
        logic        zf;
        logic        of;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START_VALID = 1'b0;
    logic        START_READY;
    logic [1:0]  OP = 2'b00;
    logic        CF_IN = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        RESULT_VALID;
    logic        RESULT_READY = 1'b0;
    logic [31:0] R;
    logic        CF_OUT, ZF_OUT, OF_OUT;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t held;

    alu_multiword_sequencer #(.WORD_WIDTH(8), .WORDS(4)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .START_VALID  (START_VALID),
        .START_READY  (START_READY),
        .OP           (OP),
        .CF_IN        (CF_IN),
        .A            (A),
        .B            (B),
        .RESULT_VALID (RESULT_VALID),
        .RESULT_READY (RESULT_READY),
        .R            (R),
        .CF_OUT       (CF_OUT),
        .ZF_OUT       (ZF_OUT),
        .OF_OUT       (OF_OUT)
    );

    always #5 CLK = ~CLK;

    // Whole-word reference: plain 33-bit add/subtract, borrow taken from bit 32.
    function automatic exp_t model(logic [1:0] op, logic cin, logic [31:0] a, logic [31:0] b);
        exp_t        m;
        logic [32:0] full;
        logic        ci;
        ci     = op[1] ? cin : 1'b0;
        full   = op[0] ? {1'b0, a} - {1'b0, b} - 33'(ci) : {1'b0, a} + {1'b0, b} + 33'(ci);
        m.r    = full[31:0];
        m.cf   = full[32];
        m.zf   = m.r == 32'd0;
        m.of   = op[0] ? (a[31] != b[31] && m.r[31] != a[31]) : (a[31] == b[31] && m.r[31] != a[31]);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic cin, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        OP = op; CF_IN = cin; A = a; B = b; START_VALID = 1'b1;
        sb.push_back(model(op, cin, a, b));
    endtask

    task automatic scramble;
        START_VALID = 1'b0;
        A = ~A; B = $urandom; OP = ~OP; CF_IN = ~CF_IN;
    endtask

    task automatic wait_result;
        int n = 0;
        while (!RESULT_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("latency", n, 4);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_r"},  R, e.r);
        chk({tag, "_cf"}, 32'(CF_OUT), 32'(e.cf));
        chk({tag, "_zf"}, 32'(ZF_OUT), 32'(e.zf));
        chk({tag, "_of"}, 32'(OF_OUT), 32'(e.of));
        chk({tag, "_start_ready"}, 32'(START_READY), 0);
    endtask

    task automatic release_result;
        RESULT_READY = 1'b1;
        @(negedge CLK);
        RESULT_READY = 1'b0;
        chk("release_valid", 32'(RESULT_VALID), 0);
        chk("release_ready", 32'(START_READY), 1);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic cin, input logic [31:0] a, input logic [31:0] b);
        send(op, cin, a, b);
        @(posedge CLK);
        @(negedge CLK);
        scramble();
        chk({tag, "_busy_ready"}, 32'(START_READY), 0);
        wait_result();
        check_result(tag);
        release_result();
    endtask

    initial begin
        #1;
        chk("rst_r", R, 0);
        chk("rst_flags", {29'd0, CF_OUT, ZF_OUT, OF_OUT}, 0);
        chk("rst_valid", 32'(RESULT_VALID), 0);
        chk("rst_ready", 32'(START_READY), 1);
        @(negedge CLK);
        RST_N = 1'b1;

        run("add_carry_ripple", 2'b00, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        run("add_wrap_zero",    2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        run("sub_borrow",       2'b01, 1'b0, 32'h0000_0000, 32'h0000_0001);
        run("sub_overflow",     2'b01, 1'b0, 32'h8000_0000, 32'h0000_0001);
        run("adc_overflow",     2'b10, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000);
        run("sbb_borrow_in",    2'b11, 1'b1, 32'h0000_0005, 32'h0000_0002);
        run("adc_no_cin",       2'b10, 1'b0, 32'h89AB_CDEF, 32'h7654_3210);

        // Backpressure: hold DONE with a new request pending.
        send(2'b00, 1'b0, 32'h1234_5678, 32'h1111_1111);
        @(posedge CLK);
        @(negedge CLK);
        scramble();
        wait_result();
        check_result("bp_first");
        held = model(2'b00, 1'b0, 32'h1234_5678, 32'h1111_1111);
        OP = 2'b01; CF_IN = 1'b0; A = 32'h0000_0010; B = 32'h0000_0020; START_VALID = 1'b1;
        sb.push_back(model(2'b01, 1'b0, 32'h0000_0010, 32'h0000_0020));
        repeat (3) begin
            @(negedge CLK);
            chk("bp_hold_r", R, held.r);
            chk("bp_hold_flags", {29'd0, CF_OUT, ZF_OUT, OF_OUT}, {29'd0, held.cf, held.zf, held.of});
            chk("bp_hold_valid", 32'(RESULT_VALID), 1);
            chk("bp_hold_ready", 32'(START_READY), 0);
        end
        RESULT_READY = 1'b1;
        @(negedge CLK);
        RESULT_READY = 1'b0;
        chk("bp_idle_no_accept", 32'(START_READY), 1);
        chk("bp_idle_valid", 32'(RESULT_VALID), 0);
        @(posedge CLK);
        @(negedge CLK);
        scramble();
        chk("bp_second_accept", 32'(START_READY), 0);
        wait_result();
        check_result("bp_second");
        release_result();

        // Asynchronous reset in the middle of BUSY (index 2).
        send(2'b00, 1'b0, 32'h1111_1111, 32'h2222_2222);
        @(posedge CLK);
        @(negedge CLK);
        scramble();
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_r", R, 0);
        chk("arst_flags", {29'd0, CF_OUT, ZF_OUT, OF_OUT}, 0);
        chk("arst_valid", 32'(RESULT_VALID), 0);
        chk("arst_ready", 32'(START_READY), 1);
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("arst_release_ready", 32'(START_READY), 1);
        chk("arst_release_valid", 32'(RESULT_VALID), 0);
        run("post_reset_add", 2'b00, 1'b0, 32'h0000_0001, 32'h0000_0001);
        chk("post_reset_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
